// File: rtl/hssl_pkt_cfg_rx.sv
// Packet receiver that diverts configuration packets to a register-bank write port
// and forwards all other packets downstream, through a 2-entry order-preserving FIFO.
module hssl_pkt_cfg_rx #(
  parameter logic [31:0] CFG_KEY = 32'hffff_fe00,
  parameter logic [31:0] CFG_MSK = 32'hffff_ff00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pkt_key_in,
  input  logic [31:0] pkt_data_in,
  input  logic        pkt_has_data_in,
  input  logic        pkt_vld_in,
  output logic        pkt_rdy_out,
  output logic [31:0] fwd_key_out,
  output logic [31:0] fwd_data_out,
  output logic        fwd_has_data_out,
  output logic        fwd_vld_out,
  input  logic        fwd_rdy_in,
  output logic [7:0]  prx_addr_out,
  output logic [31:0] prx_wdata_out,
  output logic        prx_en_out,
  output logic        cfg_cnt_out,
  output logic        cfg_err_out
);

  logic [1:0][31:0] key_q, data_q;
  logic [1:0]       has_q;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       occ, occ_nxt;

  logic [31:0] head_key, head_data;
  logic        head_has, head_vld, head_cfg;
  logic        push, pop, fwd_free;

  assign head_vld  = (occ != 2'd0);
  assign head_key  = key_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_has  = has_q[rd_ptr];
  assign head_cfg  = ((head_key & CFG_MSK) == (CFG_KEY & CFG_MSK));

  // Config heads never wait on downstream; forward heads need a free output register.
  assign fwd_free = !fwd_vld_out || fwd_rdy_in;
  assign pop      = head_vld && (head_cfg || fwd_free);
  assign push     = pkt_vld_in && pkt_rdy_out;

  always_comb begin
    occ_nxt = occ;
    if (push && !pop)      occ_nxt = occ + 2'd1;
    else if (pop && !push) occ_nxt = occ - 2'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_q       <= '0;
      data_q      <= '0;
      has_q       <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      pkt_rdy_out <= 1'b0;
    end else begin
      if (push) begin
        key_q[wr_ptr]  <= pkt_key_in;
        data_q[wr_ptr] <= pkt_data_in;
        has_q[wr_ptr]  <= pkt_has_data_in;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ         <= occ_nxt;
      pkt_rdy_out <= (occ_nxt != 2'd2);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prx_en_out    <= 1'b0;
      cfg_cnt_out   <= 1'b0;
      cfg_err_out   <= 1'b0;
      prx_addr_out  <= 8'd0;
      prx_wdata_out <= 32'd0;
    end else begin
      prx_en_out  <= pop && head_cfg && head_has;
      cfg_cnt_out <= pop && head_cfg && head_has;
      cfg_err_out <= pop && head_cfg && !head_has;
      if (pop && head_cfg && head_has) begin
        prx_addr_out  <= head_key[7:0];
        prx_wdata_out <= head_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fwd_vld_out      <= 1'b0;
      fwd_key_out      <= 32'd0;
      fwd_data_out     <= 32'd0;
      fwd_has_data_out <= 1'b0;
    end else if (pop && !head_cfg) begin
      fwd_vld_out      <= 1'b1;
      fwd_key_out      <= head_key;
      fwd_data_out     <= head_data;
      fwd_has_data_out <= head_has;
    end else if (fwd_rdy_in) begin
      fwd_vld_out <= 1'b0;
    end
  end

endmodule
